// File: rtl/sid_i2s_out.sv
// sid_i2s_out: takes the SID core's 18-bit stereo output, low-passes it at the
// ce_1m rate, decimates to FS_HZ, removes DC, saturates to 16 bits and streams
// the result as a Philips I2S frame (64 BCLK per frame, data 1 BCLK after LRCK).
module sid_i2s_out #(
    parameter int CLK_HZ   = 31500000,
    parameter int FS_HZ    = 48000,
    parameter int LP_SHIFT = 2,
    parameter int DC_SHIFT = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ce_1m,
    input  logic signed [17:0] audio_l,
    input  logic signed [17:0] audio_r,
    input  logic               mute,
    output logic signed [15:0] sample_out_l,
    output logic signed [15:0] sample_out_r,
    output logic               sample_valid,
    output logic               i2s_bclk,
    output logic               i2s_lrck,
    output logic               i2s_data
);

    // Two half-ticks per BCLK period, 64 BCLK per frame.
    localparam logic [32:0] PH_INC = 33'(128 * FS_HZ);
    localparam logic [32:0] PH_MOD = 33'(CLK_HZ);

    typedef enum logic [2:0] {IDLE, CAP, CALC_L, CALC_R, LOAD} state_t;

    state_t             state, state_next;
    logic [31:0]        phase;
    logic [32:0]        phase_sum;
    logic               half_tick, fall_tick, frame_tick;
    logic [5:0]         bitcnt;
    logic signed [17:0] lp_l, lp_r, x_l, x_r;
    logic signed [23:0] xp_l, xp_r, y_l, y_r;
    logic signed [17:0] x_sel;
    logic signed [23:0] x_ext, xp_sel, yp_sel, y_new;
    logic [63:0]        sr;
    logic signed [15:0] s_l, s_r;

    // One-pole low-pass step; the 19-bit difference keeps full-scale steps exact.
    function automatic logic signed [17:0] lp_step(input logic signed [17:0] lp,
                                                   input logic signed [17:0] a);
        logic signed [18:0] diff;
        logic signed [18:0] sh;
        diff = $signed({a[17], a}) - $signed({lp[17], lp});
        sh   = diff >>> LP_SHIFT;
        return lp + sh[17:0];
    endfunction

    // Drop the two guard bits and clamp into the DAC's 16-bit range.
    function automatic logic signed [15:0] sat16(input logic signed [23:0] y);
        logic signed [23:0] t;
        t = y >>> 2;
        if (t > 24'sd32767)
            return 16'sh7FFF;
        else if (t < -24'sd32768)
            return 16'sh8000;
        else
            return t[15:0];
    endfunction

    assign phase_sum  = {1'b0, phase} + PH_INC;
    assign half_tick  = (phase_sum >= PH_MOD);
    assign fall_tick  = half_tick && i2s_bclk;
    assign frame_tick = fall_tick && (bitcnt == 6'd63);
    assign i2s_lrck   = bitcnt[5];

    // Fractional phase accumulator producing BCLK and the bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= '0;
            i2s_bclk <= 1'b0;
            bitcnt   <= '0;
        end else begin
            if (half_tick) begin
                phase    <= 32'(phase_sum - PH_MOD);
                i2s_bclk <= ~i2s_bclk;
                if (i2s_bclk)
                    bitcnt <= bitcnt + 6'd1;
            end else begin
                phase <= phase_sum[31:0];
            end
        end
    end

    // Anti-alias low-pass, advanced on every ce_1m.
    always_ff @(posedge clk) begin
        if (reset) begin
            lp_l <= '0;
            lp_r <= '0;
        end else if (ce_1m) begin
            lp_l <= lp_step(lp_l, audio_l);
            lp_r <= lp_step(lp_r, audio_r);
        end
    end

    // Frame FSM state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Frame FSM next state; a frame_tick outside IDLE is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (frame_tick) state_next = CAP;
            CAP:     state_next = CALC_L;
            CALC_L:  state_next = CALC_R;
            CALC_R:  state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shared DC-blocker adder, steered to left in CALC_L and right in CALC_R.
    always_comb begin
        x_sel  = x_l;
        xp_sel = xp_l;
        yp_sel = y_l;
        if (state == CALC_R) begin
            x_sel  = x_r;
            xp_sel = xp_r;
            yp_sel = y_r;
        end
        x_ext = {{6{x_sel[17]}}, x_sel};
        y_new = x_ext - xp_sel + yp_sel - (yp_sel >>> DC_SHIFT);
    end

    assign s_l = mute ? 16'sd0 : sat16(y_l);
    assign s_r = mute ? 16'sd0 : sat16(y_r);

    // Decimation capture and DC-blocker state; y_c doubles as the previous output.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_l  <= '0;
            x_r  <= '0;
            xp_l <= '0;
            xp_r <= '0;
            y_l  <= '0;
            y_r  <= '0;
        end else begin
            case (state)
                CAP: begin
                    x_l <= lp_l;
                    x_r <= lp_r;
                end
                CALC_L: begin
                    y_l  <= y_new;
                    xp_l <= {{6{x_l[17]}}, x_l};
                end
                CALC_R: begin
                    y_r  <= y_new;
                    xp_r <= {{6{x_r[17]}}, x_r};
                end
                default: ;
            endcase
        end
    end

    // Serialiser: load at LOAD, shift out MSB-first on each falling BCLK tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr           <= '0;
            i2s_data     <= 1'b0;
            sample_out_l <= '0;
            sample_out_r <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= (state == LOAD);
            if (state == LOAD) begin
                sr           <= {s_l, 16'h0000, s_r, 16'h0000};
                sample_out_l <= s_l;
                sample_out_r <= s_r;
            end else if (fall_tick) begin
                sr <= {sr[62:0], 1'b0};
            end
            if (fall_tick)
                i2s_data <= sr[63];
        end
    end

endmodule

// File: tb/tb_sid_i2s_out.sv
// Directed bench for sid_i2s_out at 24.576 MHz / 48 kHz (BCLK = clk/8,
// frame = 512 clk), LP_SHIFT=0 so the low-pass output equals the input.
module tb_sid_i2s_out;

    logic               clk, reset, ce_1m, mute;
    logic signed [17:0] audio_l, audio_r;
    logic signed [15:0] sample_out_l, sample_out_r;
    logic               sample_valid, i2s_bclk, i2s_lrck, i2s_data;

    int   checks   = 0;
    int   failures = 0;
    logic data_seen;

    sid_i2s_out #(
        .CLK_HZ  (24576000),
        .FS_HZ   (48000),
        .LP_SHIFT(0),
        .DC_SHIFT(10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ce_1m       (ce_1m),
        .audio_l     (audio_l),
        .audio_r     (audio_r),
        .mute        (mute),
        .sample_out_l(sample_out_l),
        .sample_out_r(sample_out_r),
        .sample_valid(sample_valid),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrck    (i2s_lrck),
        .i2s_data    (i2s_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Roughly 1 MHz enable: one pulse every 24 clk.
    initial begin
        ce_1m = 1'b0;
        forever begin
            repeat (23) @(negedge clk);
            ce_1m = 1'b1;
            @(negedge clk);
            ce_1m = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        data_seen = data_seen | i2s_data;
    endtask

    // Wait (bounded) for the next sample_valid pulse.
    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!sample_valid && n < 600);
        chk(tag, {31'd0, sample_valid}, 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Serial data may only change on the clk where BCLK goes 1 -> 0.
    logic d_prev = 1'b0, b_prev = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!reset && (i2s_data !== d_prev))
            chk("data_on_fall", {30'd0, b_prev, i2s_bclk}, 2);
        d_prev = i2s_data;
        b_prev = i2s_bclk;
    end

    initial begin
        logic [63:0] exp_frame;
        logic [62:0] got, lr;
        logic        prev;
        int          rises, extra_valid;

        reset = 1'b1; mute = 1'b0; data_seen = 1'b0;
        audio_l = 18'sd4096; audio_r = -18'sd4096;

        // Reset state
        repeat (4) tick();
        chk("rst_bclk", {31'd0, i2s_bclk}, 0);
        chk("rst_lrck", {31'd0, i2s_lrck}, 0);
        chk("rst_data", {31'd0, i2s_data}, 0);
        chk("rst_valid", {31'd0, sample_valid}, 0);
        chk("rst_out_l", sample_out_l, 0);
        chk("rst_out_r", sample_out_r, 0);

        // Clock generation and framing after release
        @(negedge clk); reset = 1'b0;
        repeat (3) tick();
        chk("bclk_clk3", {31'd0, i2s_bclk}, 0);
        tick();
        chk("bclk_clk4", {31'd0, i2s_bclk}, 1);
        repeat (251) tick();
        chk("lrck_clk255", {31'd0, i2s_lrck}, 0);
        tick();
        chk("lrck_clk256", {31'd0, i2s_lrck}, 1);
        repeat (259) tick();
        chk("valid_clk515", {31'd0, sample_valid}, 0);
        tick();
        chk("valid_clk516", {31'd0, sample_valid}, 1);
        chk("frame1_l", sample_out_l, 1024);
        chk("frame1_r", sample_out_r, -1024);

        // Capture slot bits 1..63 of the frame carrying those samples
        exp_frame = {1'b0, 16'h0400, 15'd0, 1'b0, 16'hFC00, 15'd0};
        got = '0; lr = '0; rises = 0; extra_valid = 0; prev = i2s_bclk;
        repeat (504) begin
            tick();
            if (sample_valid) extra_valid++;
            if (!prev && i2s_bclk) begin
                got = {got[61:0], i2s_data};
                lr  = {lr[61:0], i2s_lrck};
                rises++;
            end
            prev = i2s_bclk;
        end
        chk("bclk_rises", rises, 63);
        chk("valid_single", extra_valid, 0);
        chk("slot_left_bits", got[62:31], exp_frame[62:31]);
        chk("slot_right_bits", {1'b0, got[30:0]}, {1'b0, exp_frame[30:0]});
        chk("lrck_left_half", {1'b0, lr[62:32]}, 0);
        chk("lrck_right_half", lr[31:0], 32'hFFFF_FFFF);
        repeat (7) tick();
        chk("valid_clk1027", {31'd0, sample_valid}, 0);
        tick();
        chk("valid_clk1028", {31'd0, sample_valid}, 1);
        chk("frame2_l", sample_out_l, 1023);
        chk("frame2_r", sample_out_r, -1023);

        // Mid-frame reset at bitcnt 20
        pulse_reset();
        repeat (164) tick();
        chk("bitcnt_pre", dut.bitcnt, 20);
        @(negedge clk); reset = 1'b1;
        tick();
        chk("mid_bitcnt", dut.bitcnt, 0);
        chk("mid_bclk", {31'd0, i2s_bclk}, 0);
        chk("mid_out_l", sample_out_l, 0);
        chk("mid_out_r", sample_out_r, 0);
        @(negedge clk); reset = 1'b0;
        repeat (3) tick();
        chk("re_bclk_clk3", {31'd0, i2s_bclk}, 0);
        tick();
        chk("re_bclk_clk4", {31'd0, i2s_bclk}, 1);
        repeat (511) tick();
        chk("re_valid_clk515", {31'd0, sample_valid}, 0);
        tick();
        chk("re_valid_clk516", {31'd0, sample_valid}, 1);
        chk("re_frame1_l", sample_out_l, 1024);

        // DC removal, then mute for frames 4..6
        audio_l = 18'sd65536; audio_r = 18'sd0;
        pulse_reset();
        wait_valid("dc_wait1");
        chk("dc_f1_l", sample_out_l, 16384);
        chk("dc_f1_r", sample_out_r, 0);
        wait_valid("dc_wait2");
        chk("dc_f2_l", sample_out_l, 16368);
        wait_valid("dc_wait3");
        chk("dc_f3_l", sample_out_l, 16352);
        mute = 1'b1;
        wait_valid("mute_wait4");
        chk("mute_f4_l", sample_out_l, 0);
        data_seen = 1'b0;
        wait_valid("mute_wait5");
        chk("mute_f5_l", sample_out_l, 0);
        wait_valid("mute_wait6");
        chk("mute_f6_l", sample_out_l, 0);
        chk("mute_f6_r", sample_out_r, 0);
        mute = 1'b0;
        wait_valid("unmute_wait7");
        chk("mute_data_zero", {31'd0, data_seen}, 0);
        chk("unmute_f7_l", sample_out_l, 16289);

        // Saturation with full-scale steps
        audio_l = 18'sd131071; audio_r = 18'sd131071;
        pulse_reset();
        wait_valid("sat_wait1");
        chk("sat_f1_l", sample_out_l, 32767);
        audio_l = -18'sd131072; audio_r = -18'sd131072;
        wait_valid("sat_wait2");
        chk("sat_neg_l", sample_out_l, -32768);
        chk("sat_neg_r", sample_out_r, -32768);
        audio_l = 18'sd131071; audio_r = 18'sd131071;
        wait_valid("sat_wait3");
        chk("sat_pos_l", sample_out_l, 32767);
        chk("sat_pos_r", sample_out_r, 32767);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
